// File: rtl/command_sequencer_if.sv
// Host <-> command_sequencer bus.
// Build option: SINGLE_STEP_EN adds the 'step' strobe.
// master: host/test side. It drives the program load port and the start/pause
//         controls, and observes the issued command and the status.
// slave : the sequencer. It takes the controls and drives command, cmd_valid,
//         busy, done and pc.
interface command_sequencer_if #(
   parameter int unsigned AW = 4
) ();
   logic          load_en;
   logic [AW-1:0] load_addr;
   logic [3:0]    load_cmd;
   logic          start;
   logic          pause;
`ifdef SINGLE_STEP_EN
   logic          step;
`endif
   logic [3:0]    command;
   logic          cmd_valid;
   logic          busy;
   logic          done;
   logic [AW-1:0] pc;

`ifdef SINGLE_STEP_EN
   modport master (output load_en, load_addr, load_cmd, start, pause, step,
                   input  command, cmd_valid, busy, done, pc);
   modport slave  (input  load_en, load_addr, load_cmd, start, pause, step,
                   output command, cmd_valid, busy, done, pc);
`else
   modport master (output load_en, load_addr, load_cmd, start, pause,
                   input  command, cmd_valid, busy, done, pc);
   modport slave  (input  load_en, load_addr, load_cmd, start, pause,
                   output command, cmd_valid, busy, done, pc);
`endif
endinterface

// File: rtl/command_sequencer.sv
// command_sequencer: stores a short program of 4-bit datapath commands and
// replays it, one command per clock, into the instruction decoder.
// Ports:
//   clock  rising-edge system clock
//   CLR    synchronous, active-high reset; it aborts a run without a done pulse
//   bus    command_sequencer_if.slave, carrying:
//          load_en, load_addr, load_cmd  program write port (IDLE only)
//          start, pause                  launch and hold controls
//          command, cmd_valid            registered command to the decoder
//          busy, done, pc                run status and next fetch address
// Build option: SINGLE_STEP_EN. When it is defined, RUN advances only on
// edges where step=1 and pause=0.
module command_sequencer #(
   parameter int unsigned AW       = 4,
   parameter logic [3:0]  HALT_CMD = 4'hF,
   parameter logic [3:0]  NOP_CMD  = 4'h0
) (
   input logic               clock,
   input logic               CLR,
   command_sequencer_if.slave bus
);
   localparam int unsigned DEPTH   = 1 << AW;
   localparam logic [AW-1:0] PC_LAST = AW'(DEPTH - 1);

   typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

   state_t        state;
   logic [3:0]    mem [DEPTH];
   logic [AW-1:0] pc_q;
   logic [3:0]    command_q;
   logic          valid_q;
   logic          busy_q;
   logic          done_q;
   logic [3:0]    word_c;
   logic          advance_c;

   // Combinational fetch from the registered pc.
   assign word_c = mem[pc_q];

`ifdef SINGLE_STEP_EN
   assign advance_c = bus.step && !bus.pause;
`else
   assign advance_c = !bus.pause;
`endif

   // Program memory: written only while idle. Reset does not clear it.
   always_ff @(posedge clock) begin
      if (!CLR && (state == IDLE) && bus.load_en)
         mem[bus.load_addr] <= bus.load_cmd;
   end

   // Sequencer FSM with registered outputs.
   always_ff @(posedge clock) begin
      if (CLR) begin
         state     <= IDLE;
         pc_q      <= '0;
         command_q <= NOP_CMD;
         valid_q   <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         done_q    <= 1'b0;
         command_q <= NOP_CMD;
         valid_q   <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  state  <= RUN;
                  pc_q   <= '0;
                  busy_q <= 1'b1;
               end
            end
            RUN: begin
               if (advance_c) begin
                  if (word_c == HALT_CMD) begin
                     state <= FINISH;
                  end else begin
                     command_q <= word_c;
                     valid_q   <= 1'b1;
                     // The last address ends the run instead of wrapping.
                     if (pc_q == PC_LAST)
                        state <= FINISH;
                     else
                        pc_q <= pc_q + AW'(1);
                  end
               end
            end
            FINISH: begin
               done_q <= 1'b1;
               busy_q <= 1'b0;
               pc_q   <= '0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.command   = command_q;
   assign bus.cmd_valid = valid_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.pc        = pc_q;
endmodule

// File: tb/tb_command_sequencer.sv
// Bench for command_sequencer. Stimulus pushes the expected issued commands
// into a queue, and an independent monitor pops and compares them on every
// cmd_valid cycle.
module tb_command_sequencer;
   localparam int unsigned AW = 4;

   logic clock = 1'b0;
   logic CLR;
   always #5 clock = ~clock;

   command_sequencer_if #(.AW(AW)) sif ();
   command_sequencer #(.AW(AW)) dut (.clock(clock), .CLR(CLR), .bus(sif));

   typedef struct packed {
      logic [3:0] cmd;
      logic [3:0] pc;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   total     = 0;
   int   bad       = 0;
   int   done_cnt  = 0;
   int   valid_cnt = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
      end
   endtask

   // Monitor: compares every issued command against the scoreboard.
   always @(negedge clock) begin
      if (sif.cmd_valid === 1'b1) begin
         valid_cnt++;
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_issue: got cmd %0h expected none at %0t", sif.command, $time);
         end else begin
            mon_e = exp_q.pop_front();
            check("issue_cmd", 32'(sif.command), 32'(mon_e.cmd));
            check("issue_pc",  32'(sif.pc),      32'(mon_e.pc));
         end
      end
      if (sif.done === 1'b1) done_cnt++;
   end

   task automatic tick();
      @(negedge clock);
   endtask

   task automatic write_word(input int a, input logic [3:0] c);
      sif.load_en   = 1'b1;
      sif.load_addr = AW'(a);
      sif.load_cmd  = c;
      tick();
      sif.load_en   = 1'b0;
   endtask

   task automatic push(input logic [3:0] c, input int p);
      exp_t e;
      e.cmd = c;
      e.pc  = 4'(p);
      exp_q.push_back(e);
   endtask

   task automatic launch();
      sif.start = 1'b1;
      tick();
      sif.start = 1'b0;
      check("start_busy",  32'(sif.busy),      32'd1);
      check("start_valid", 32'(sif.cmd_valid), 32'd0);
   endtask

   // Waits, within a bound, for done. n = negedges from the call until done is seen.
   task automatic wait_done(input int limit, output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (sif.done !== 1'b1 && n < limit);
      if (sif.done !== 1'b1) begin
         total++;
         bad++;
         $display("FAIL done_timeout: got no done expected done within %0d cycles", limit);
      end else begin
         check("done_busy", 32'(sif.busy), 32'd0);
         check("done_pc",   32'(sif.pc),   32'd0);
         tick();
         check("done_pulse_width", 32'(sif.done), 32'd0);
      end
   endtask

   int n;
   int v0;
   int d0;

   initial begin
      CLR           = 1'b1;
      sif.load_en   = 1'b0;
      sif.load_addr = '0;
      sif.load_cmd  = 4'h0;
      sif.start     = 1'b0;
      sif.pause     = 1'b0;
`ifdef SINGLE_STEP_EN
      sif.step      = 1'b1;
`endif
      repeat (2) tick();
      check("rst_command", 32'(sif.command),   32'h0);
      check("rst_valid",   32'(sif.cmd_valid), 32'd0);
      check("rst_busy",    32'(sif.busy),      32'd0);
      check("rst_done",    32'(sif.done),      32'd0);
      check("rst_pc",      32'(sif.pc),        32'd0);
      CLR = 1'b0;
      tick();

      // Basic three-command program.
      write_word(0, 4'h1); write_word(1, 4'h2); write_word(2, 4'h5); write_word(3, 4'hF);
      push(4'h1, 1); push(4'h2, 2); push(4'h5, 3);
      v0 = valid_cnt;
      launch();
      wait_done(20, n);
      check("basic_done_latency", 32'(n), 32'd5);
      check("basic_valid_count",  32'(valid_cnt - v0), 32'd3);

      // Pause for two cycles after the first issue.
      push(4'h1, 1); push(4'h2, 2); push(4'h5, 3);
      launch();
      tick();
      sif.pause = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick();
         check("pause_cmd",   32'(sif.command),   32'h0);
         check("pause_valid", 32'(sif.cmd_valid), 32'd0);
         check("pause_pc",    32'(sif.pc),        32'd1);
         check("pause_busy",  32'(sif.busy),      32'd1);
      end
      sif.pause = 1'b0;
      wait_done(20, n);
      check("pause_done_latency", 32'(n), 32'd4);

      // Full memory without HALT: sixteen issues, no wrap.
      for (int i = 0; i < 16; i++) write_word(i, 4'h3);
      for (int i = 0; i < 16; i++) push(4'h3, (i < 15) ? i + 1 : 15);
      v0 = valid_cnt;
      launch();
      wait_done(40, n);
      check("full_done_latency", 32'(n), 32'd17);
      check("full_valid_count",  32'(valid_cnt - v0), 32'd16);

      // Empty program.
      write_word(0, 4'hF);
      v0 = valid_cnt;
      launch();
      wait_done(20, n);
      check("empty_done_latency", 32'(n), 32'd2);
      check("empty_valid_count",  32'(valid_cnt - v0), 32'd0);

      // Mid-run CLR after the second command, then a fresh run.
      write_word(0, 4'h1); write_word(1, 4'h2); write_word(2, 4'h5); write_word(3, 4'hF);
      push(4'h1, 1); push(4'h2, 2);
      launch();
      tick();
      tick();
      CLR = 1'b1;
      tick();
      check("abort_cmd",   32'(sif.command),   32'h0);
      check("abort_valid", 32'(sif.cmd_valid), 32'd0);
      check("abort_busy",  32'(sif.busy),      32'd0);
      check("abort_pc",    32'(sif.pc),        32'd0);
      check("abort_done",  32'(sif.done),      32'd0);
      CLR = 1'b0;
      d0 = done_cnt;
      repeat (4) tick();
      check("abort_no_done", 32'(done_cnt - d0), 32'd0);
      push(4'h1, 1); push(4'h2, 2); push(4'h5, 3);
      launch();
      wait_done(20, n);
      check("rerun_done_latency", 32'(n), 32'd5);

      // start and load_en while busy are ignored; word 5 keeps its value.
      write_word(3, 4'h3); write_word(4, 4'h4); write_word(5, 4'h6); write_word(6, 4'hF);
      push(4'h1, 1); push(4'h2, 2); push(4'h5, 3); push(4'h3, 4); push(4'h4, 5); push(4'h6, 6);
      launch();
      sif.start     = 1'b1;
      sif.load_en   = 1'b1;
      sif.load_addr = AW'(5);
      sif.load_cmd  = 4'h7;
      tick();
      tick();
      sif.start   = 1'b0;
      sif.load_en = 1'b0;
      wait_done(20, n);
      check("busy_ign_done_latency", 32'(n), 32'd6);
      push(4'h1, 1); push(4'h2, 2); push(4'h5, 3); push(4'h3, 4); push(4'h4, 5); push(4'h6, 6);
      launch();
      wait_done(20, n);
      check("readback_done_latency", 32'(n), 32'd8);

      tick();
      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      check("done_total",       32'(done_cnt),     32'd7);
      check("valid_total",      32'(valid_cnt),    32'd39);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
